// File: rtl/dsp_fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem requests,
// 2-entry word FIFO toward decode, and jump/branch redirect with response drain.
module dsp_fetch_unit #(
  parameter int unsigned INST_WORD_LEN = 32,
  parameter int unsigned PC_WIDTH      = 16,
  parameter logic [PC_WIDTH-1:0]      RESET_PC = '0,
  parameter logic [INST_WORD_LEN-1:0] BUBBLE   = INST_WORD_LEN'(32'hFC00_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ready,
  input  logic [INST_WORD_LEN-1:0] imem_rdata,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  input  logic                     stall,
  output logic [INST_WORD_LEN-1:0] instruction,
  output logic                     instr_valid,
  output logic [PC_WIDTH-1:0]      instr_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]               state, state_d;
  logic [PC_WIDTH-1:0]      pc, pc_d;
  logic [1:0]               count, count_d;
  logic                     req_d;
  logic [PC_WIDTH-1:0]      addr_d;
  logic [INST_WORD_LEN-1:0] instr_d;
  logic [PC_WIDTH-1:0]      ipc_d;
  logic                     valid_d;
  // Second FIFO slot; the head slot is the instruction/instr_pc register pair.
  logic [INST_WORD_LEN-1:0] buf_data, buf_data_d;
  logic [PC_WIDTH-1:0]      buf_pc, buf_pc_d;
  logic                     fire, push, pop;

  // Next-state, FIFO update and registered-output computation.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    count_d    = count;
    instr_d    = instruction;
    ipc_d      = instr_pc;
    buf_data_d = buf_data;
    buf_pc_d   = buf_pc;
    fire       = imem_req & imem_ready;
    pop        = instr_valid & ~stall;
    push       = 1'b0;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = 2'd0;
      instr_d = BUBBLE;
      case (state)
        REQ:     state_d = (imem_req && !imem_ready) ? DRAIN : REQ;
        DRAIN:   state_d = imem_ready ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      push    = (state == REQ) && fire;
      count_d = 2'(count + {1'b0, push} - {1'b0, pop});
      if (push) pc_d = pc + PC_WIDTH'(1);

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            instr_d = imem_rdata;
            ipc_d   = imem_addr;
          end else begin
            buf_data_d = imem_rdata;
            buf_pc_d   = imem_addr;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            instr_d = buf_data;
            ipc_d   = buf_pc;
          end else begin
            instr_d = BUBBLE;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            instr_d    = buf_data;
            ipc_d      = buf_pc;
            buf_data_d = imem_rdata;
            buf_pc_d   = imem_addr;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = imem_addr;
          end
        end
        default: ;
      endcase

      case (state)
        DRAIN:   state_d = imem_ready ? REQ : DRAIN;
        default: state_d = (count_d < 2'd2) ? REQ : IDLE;
      endcase
    end

    valid_d = (count_d != 2'd0);
    req_d   = (state_d != IDLE);
    // While draining, the old address stays on the bus until the discarded response.
    addr_d  = (state_d == DRAIN) ? imem_addr : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      count       <= 2'd0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instruction <= BUBBLE;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      buf_data    <= BUBBLE;
      buf_pc      <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      count       <= count_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      instr_pc    <= ipc_d;
      buf_data    <= buf_data_d;
      buf_pc      <= buf_pc_d;
    end
  end

  // Request gating must never let a word land in a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (count == 2'd2) && !pop));
  end

endmodule
